// File: rtl/led_line_shifter_pkg.sv
// Shared definitions for the LED line shifter: geometry, RAM word and
// address layouts, FSM state encoding and an address packing helper.
package led_line_shifter_pkg;

  localparam int COLS       = 64;
  localparam int COL_BITS   = $clog2(COLS);
  localparam int ROW_BITS   = 5;
  localparam int PWM_BITS   = 4;
  localparam int COLOR_BITS = 4;
  localparam int PLANE_BITS = $clog2(COLOR_BITS);

  localparam int RAM_DATA_W = 6 * COLOR_BITS;
  localparam int RAM_ADDR_W = 1 + ROW_BITS + COL_BITS;

  // RAM word layout {r0,g0,b0,r1,g1,b1}, r0 in the MSBs
  localparam int R0_LSB = 5 * COLOR_BITS;
  localparam int G0_LSB = 4 * COLOR_BITS;
  localparam int B0_LSB = 3 * COLOR_BITS;
  localparam int R1_LSB = 2 * COLOR_BITS;
  localparam int G1_LSB = 1 * COLOR_BITS;
  localparam int B1_LSB = 0;

  // RAM address layout {base, row, col}, shared with the RAM writer
  localparam int ADDR_COL_LSB  = 0;
  localparam int ADDR_ROW_LSB  = COL_BITS;
  localparam int ADDR_BASE_BIT = COL_BITS + ROW_BITS;

  typedef logic [COL_BITS-1:0]   col_t;
  typedef logic [ROW_BITS-1:0]   row_t;
  typedef logic [PWM_BITS-1:0]   pwm_t;
  typedef logic [RAM_ADDR_W-1:0] ram_addr_t;
  typedef logic [RAM_DATA_W-1:0] ram_data_t;

  // FSM state encoding
  localparam int STATE_W = 3;
  localparam logic [STATE_W-1:0] ST_IDLE     = 3'd0;
  localparam logic [STATE_W-1:0] ST_FETCH    = 3'd1;
  localparam logic [STATE_W-1:0] ST_SHIFT_LO = 3'd2;
  localparam logic [STATE_W-1:0] ST_SHIFT_HI = 3'd3;
  localparam logic [STATE_W-1:0] ST_DONE     = 3'd4;

  function automatic ram_addr_t make_ram_addr(input logic base, input row_t row, input col_t col);
    return {base, row, col};
  endfunction

endpackage

// File: rtl/led_line_shifter_if.sv
// Line handshake and frame RAM read port between the row controller / RAM
// (master) and the line shifter (slave).
//
// Handshake: next_line_begin is a single-cycle pulse; addr/pwm/base are
// sampled in that same cycle. The shifter only takes a begin when it is idle
// or in its final (done) cycle; otherwise the pulse is dropped. Each accepted
// begin yields exactly one single-cycle next_line_done once the last column
// has been clocked out. RAM reads: ram_data is valid one cycle after the
// cycle in which ram_rd_en is high, and holds until the next read.
interface led_line_shifter_if;
  import led_line_shifter_pkg::*;

  logic      next_line_begin;
  row_t      next_line_addr;
  pwm_t      next_line_pwm;
  logic      base_addr;
  logic      next_line_done;
  logic      ram_rd_en;
  ram_addr_t ram_addr;
  ram_data_t ram_data;

  modport master (
    output next_line_begin, next_line_addr, next_line_pwm, base_addr, ram_data,
    input  next_line_done, ram_rd_en, ram_addr
  );

  modport slave (
    input  next_line_begin, next_line_addr, next_line_pwm, base_addr, ram_data,
    output next_line_done, ram_rd_en, ram_addr
  );
endinterface

// File: rtl/led_line_shifter_plane_slice.sv
// Picks one bit plane out of a RAM word for all six colour channels.
// pwm 0 selects the MSB of each channel; pwm beyond the colour depth
// yields all zeros so the line is still shifted, just dark.
module led_plane_slice
  import led_line_shifter_pkg::*;
(
  input  ram_data_t  ram_data,
  input  pwm_t       pwm,
  output logic [5:0] plane_bits
);

  logic [COLOR_BITS-1:0] r0_ch, g0_ch, b0_ch, r1_ch, g1_ch, b1_ch;
  logic [PLANE_BITS-1:0] plane_idx;

  assign r0_ch = ram_data[R0_LSB +: COLOR_BITS];
  assign g0_ch = ram_data[G0_LSB +: COLOR_BITS];
  assign b0_ch = ram_data[B0_LSB +: COLOR_BITS];
  assign r1_ch = ram_data[R1_LSB +: COLOR_BITS];
  assign g1_ch = ram_data[G1_LSB +: COLOR_BITS];
  assign b1_ch = ram_data[B1_LSB +: COLOR_BITS];

  assign plane_idx = PLANE_BITS'(COLOR_BITS - 1) - pwm[PLANE_BITS-1:0];

  // Select the plane bit of each channel, or zero when pwm is out of range
  always_comb begin
    plane_bits = '0;
    if (pwm < PWM_BITS'(COLOR_BITS)) begin
      plane_bits = {r0_ch[plane_idx], g0_ch[plane_idx], b0_ch[plane_idx],
                    r1_ch[plane_idx], g1_ch[plane_idx], b1_ch[plane_idx]};
    end
  end

endmodule

// File: rtl/led_line_shifter.sv
// HUB75 line shifter: on a begin pulse, reads one row pair from frame RAM
// and clocks the selected bit plane out on the panel data pins.
//
// Outputs are registered and lag the state by one edge: the read for a
// column is issued while leaving SHIFT_LO of the previous column (or on
// accepting begin for column 0), its data is loaded into rgb when leaving
// SHIFT_LO, and sclk rises when leaving SHIFT_HI. rgb therefore only moves
// when sclk falls (or is already low) and is stable over every sclk rise.
module led_line_shifter
  import led_line_shifter_pkg::*;
(
  input  logic               clk_25MHz,
  input  logic               rst_n,
  led_line_shifter_if.slave  bus,
  output logic               sclk,
  output logic               r0,
  output logic               g0,
  output logic               b0,
  output logic               r1,
  output logic               g1,
  output logic               b1,
  output logic [STATE_W-1:0] state_dbg
);

  localparam col_t COL_LAST = col_t'(COLS - 1);
  localparam col_t COL_ONE  = col_t'(1);

  logic [STATE_W-1:0] state;
  row_t               row_q;
  pwm_t               pwm_q;
  logic               base_q;
  col_t               col_q;
  logic               rd_en_q;
  ram_addr_t          ram_addr_q;
  logic               done_q;
  logic               sclk_q;
  logic [5:0]         rgb_q;
  logic [5:0]         plane_bits;
  logic               accept;

  led_plane_slice u_plane_slice (
    .ram_data   (bus.ram_data),
    .pwm        (pwm_q),
    .plane_bits (plane_bits)
  );

  // A new line may start from idle or in the done cycle of the previous one
  assign accept = bus.next_line_begin && ((state == ST_IDLE) || (state == ST_DONE));

  // Line sequencer: fetch column 0, then alternate low/high shift clock phases
  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      row_q      <= '0;
      pwm_q      <= '0;
      base_q     <= 1'b0;
      col_q      <= '0;
      rd_en_q    <= 1'b0;
      ram_addr_q <= '0;
      done_q     <= 1'b0;
      sclk_q     <= 1'b0;
      rgb_q      <= '0;
    end else begin
      rd_en_q <= 1'b0;
      done_q  <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (state == ST_DONE) begin
            sclk_q <= 1'b0;
            done_q <= 1'b1;
          end
          state <= ST_IDLE;
          if (accept) begin
            row_q      <= bus.next_line_addr;
            pwm_q      <= bus.next_line_pwm;
            base_q     <= bus.base_addr;
            col_q      <= '0;
            rd_en_q    <= 1'b1;
            ram_addr_q <= make_ram_addr(bus.base_addr, bus.next_line_addr, '0);
            state      <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          state <= ST_SHIFT_LO;
        end
        ST_SHIFT_LO: begin
          sclk_q <= 1'b0;
          rgb_q  <= plane_bits;
          if (col_q != COL_LAST) begin
            rd_en_q    <= 1'b1;
            ram_addr_q <= make_ram_addr(base_q, row_q, col_q + COL_ONE);
          end
          state <= ST_SHIFT_HI;
        end
        ST_SHIFT_HI: begin
          sclk_q <= 1'b1;
          if (col_q == COL_LAST) begin
            state <= ST_DONE;
          end else begin
            col_q <= col_q + COL_ONE;
            state <= ST_SHIFT_LO;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.next_line_done = done_q;
  assign bus.ram_rd_en      = rd_en_q;
  assign bus.ram_addr       = ram_addr_q;

  assign sclk = sclk_q;
  assign {r0, g0, b0, r1, g1, b1} = rgb_q;
  assign state_dbg = state;

endmodule
